// File: rtl/uart_axis_pkg.sv
// Shared encodings for the single-byte axis-query UART protocol:
// axis codes, command bytes, reply header, response error codes and FSM states.
package uart_axis_pkg;

  localparam logic [1:0] AXIS_X   = 2'd0;
  localparam logic [1:0] AXIS_Y   = 2'd1;
  localparam logic [1:0] AXIS_Z   = 2'd2;
  localparam logic [1:0] AXIS_ILL = 2'd3;

  localparam logic [7:0] CMD_X = 8'h78;
  localparam logic [7:0] CMD_Y = 8'h79;
  localparam logic [7:0] CMD_Z = 8'h7A;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'h00;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_HDR     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_AXIS    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RX_HDR = 3'd2,
    ST_RX_LO  = 3'd3,
    ST_RX_HI  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Command bytes are consecutive, so the legal axes map by offset from 'x'.
  function automatic logic [7:0] cmd_byte(input logic [1:0] axis);
    return CMD_X + {6'b0, axis};
  endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// Reply timeout counter: cleared on command issue, counts while enabled and
// flags expiry when it reaches TIMEOUT_CYCLES-1, holding there afterwards.
module uart_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_axis_requester.sv
// Host-side axis-query initiator: sends 'x'/'y'/'z' through a byte UART
// transmitter and assembles the 3-byte reply into one 16-bit sample with status.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | ready for a request; rx bytes here are strays and dropped
// ST_ISSUE  | command latched, waiting for transmitter idle to pulse start
// ST_RX_HDR | waiting for header byte, timeout running
// ST_RX_LO  | waiting for data low byte, timeout running
// ST_RX_HI  | waiting for data high byte, timeout running
// ST_DONE   | response complete, resp_valid pulses on exit
module uart_axis_requester
  import uart_axis_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] HDR_BYTE       = HDR_BYTE_DEFAULT
) (
  input  logic        CLK_50,
  input  logic        RST,
  input  logic        req_valid,
  input  logic [1:0]  req_axis,
  output logic        req_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_axis,
  output logic [1:0]  resp_err,
  output logic        stray_byte
);

  state_t      state_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic        resp_valid_q;
  logic [7:0]  data_lo_q, data_hi_q;
  logic [1:0]  resp_axis_q;
  logic [1:0]  resp_err_q;
  logic        stray_q;
  logic        to_en, to_clr, to_expired;

  assign to_clr = (state_q == ST_ISSUE);
  assign to_en  = (state_q == ST_RX_HDR) || (state_q == ST_RX_LO) || (state_q == ST_RX_HI);

  uart_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (CLK_50),
    .rst_i     (RST),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  // A byte arriving in the expiry cycle takes priority over the timeout.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      resp_valid_q <= 1'b0;
      data_lo_q    <= '0;
      data_hi_q    <= '0;
      resp_axis_q  <= '0;
      resp_err_q   <= ERR_OK;
      stray_q      <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      stray_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          stray_q <= rx_ready;
          if (req_valid) begin
            resp_axis_q <= req_axis;
            if (req_axis == AXIS_ILL) begin
              resp_err_q <= ERR_AXIS;
              state_q    <= ST_DONE;
            end else begin
              tx_data_q <= cmd_byte(req_axis);
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            state_q    <= ST_RX_HDR;
          end
        end
        ST_RX_HDR: begin
          if (rx_ready) begin
            if (rx_data == HDR_BYTE) begin
              state_q <= ST_RX_LO;
            end else begin
              resp_err_q <= ERR_HDR;
              state_q    <= ST_DONE;
            end
          end else if (to_expired) begin
            resp_err_q <= ERR_TIMEOUT;
            state_q    <= ST_DONE;
          end
        end
        ST_RX_LO: begin
          if (rx_ready) begin
            data_lo_q <= rx_data;
            state_q   <= ST_RX_HI;
          end else if (to_expired) begin
            resp_err_q <= ERR_TIMEOUT;
            state_q    <= ST_DONE;
          end
        end
        ST_RX_HI: begin
          if (rx_ready) begin
            data_hi_q  <= rx_data;
            resp_err_q <= ERR_OK;
            state_q    <= ST_DONE;
          end else if (to_expired) begin
            resp_err_q <= ERR_TIMEOUT;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          resp_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = {data_hi_q, data_lo_q};
  assign resp_axis  = resp_axis_q;
  assign resp_err   = resp_err_q;
  assign stray_byte = stray_q;

endmodule
